// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
// Shared definitions for the single-clock FIFO slice.
//   ptr_width_of : address width needed for a given entry count
//   ptr_t        : pointer type (address bits plus one wrap bit) for the
//                  default 16-entry configuration
//   ptr_diff     : modular pointer difference; callers truncate the result
//                  to their own pointer width to get the occupancy
package sync_fifo_pkg;

  function automatic int ptr_width_of(input int depth);
    return $clog2(depth);
  endfunction

  localparam int DEFAULT_DEPTH     = 16;
  localparam int DEFAULT_PTR_WIDTH = ptr_width_of(DEFAULT_DEPTH);

  typedef logic [DEFAULT_PTR_WIDTH:0] ptr_t;

  // The pointers wrap modulo 2*DEPTH, so the plain difference truncated
  // to PTR_WIDTH+1 bits is always the true occupancy.
  function automatic logic [31:0] ptr_diff(input logic [31:0] wptr,
                                           input logic [31:0] rptr);
    return wptr - rptr;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram
// DEPTH x WIDTH storage with one write port and one registered read port.
// The array itself is never reset; only the read-data register is, so
// the FIFO output starts at zero.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   wr_en/wr_addr     write strobe and address, wr_data written on the edge
//   rd_en/rd_addr     read strobe and address
//   rd_data           registered read data, holds when rd_en is low
module sync_fifo_ram #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with binary wrap-bit pointers, occupancy count,
// programmable almost-full/almost-empty flags and a read-valid strobe.
// Optional macro SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_en, din      write request and data (dropped while full)
//   rd_en           read request (dropped while empty)
//   dout            registered read data, 1-cycle latency
//   dout_valid      pulses the cycle dout holds a newly read word
//   full, empty     occupancy == DEPTH / == 0
//   almost_full     count >= AFULL_THRESH
//   almost_empty    count <= AEMPTY_THRESH
//   count           occupancy 0..DEPTH
//   overflow        sticky, write attempted while full (macro only)
//   underflow       sticky, read attempted while empty (macro only)
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int PTR_WIDTH     = ptr_width_of(DEPTH),
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     din,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                 overflow,
  output logic                 underflow
`endif
);

  localparam int CW = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] AFULL_T  = CW'(AFULL_THRESH);
  localparam logic [PTR_WIDTH:0] AEMPTY_T = CW'(AEMPTY_THRESH);

  logic [PTR_WIDTH:0] wptr_q, wptr_d;
  logic [PTR_WIDTH:0] rptr_q, rptr_d;
  logic               dout_valid_q, dout_valid_d;
  logic               wr_accept;
  logic               rd_accept;

  // Flags come straight from the registered pointers, so they reflect an
  // accepted operation one cycle later.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PTR_WIDTH] != rptr_q[PTR_WIDTH]) &&
                 (wptr_q[PTR_WIDTH-1:0] == rptr_q[PTR_WIDTH-1:0]);
  assign count = CW'(ptr_diff(32'(wptr_q), 32'(rptr_q)));
  assign almost_full  = (count >= AFULL_T);
  assign almost_empty = (count <= AEMPTY_T);

  // Each request is gated by its own flag, so full+rd+wr only reads and
  // empty+rd+wr only writes (no write-through).
  assign wr_accept = wr_en & ~full;
  assign rd_accept = rd_en & ~empty;

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    dout_valid_d = rd_accept;
    if (wr_accept) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_accept) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout_valid = dout_valid_q;

  sync_fifo_ram #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (wptr_q[PTR_WIDTH-1:0]),
    .wr_data (din),
    .rd_en   (rd_accept),
    .rd_addr (rptr_q[PTR_WIDTH-1:0]),
    .rd_data (dout)
  );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky: once set, only rst clears them.
  always_comb begin
    overflow_d  = overflow_q  | (wr_en & full);
    underflow_d = underflow_q | (rd_en & empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo
// Directed testbench for sync_fifo at WIDTH=8, DEPTH=16, AFULL_THRESH=14,
// AEMPTY_THRESH=2. Expected values are hand-derived from the FIFO rules.
module tb_sync_fifo;

   logic       clock;
   logic       reset;
   logic       wrEn;
   logic [7:0] din;
   logic       rdEn;
   logic [7:0] dout;
   logic       doutValid;
   logic       full;
   logic       empty;
   logic       almostFull;
   logic       almostEmpty;
   logic [4:0] count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic       overflow;
   logic       underflow;
`endif

   int testsRun;
   int testsFailed;

   sync_fifo #(
      .WIDTH         (8),
      .DEPTH         (16),
      .AFULL_THRESH  (14),
      .AEMPTY_THRESH (2)
   ) dut (
      .clk          (clock),
      .rst          (reset),
      .wr_en        (wrEn),
      .din          (din),
      .rd_en        (rdEn),
      .dout         (dout),
      .dout_valid   (doutValid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almostFull),
      .almost_empty (almostEmpty),
      .count        (count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      ,
      .overflow     (overflow),
      .underflow    (underflow)
`endif
   );

   // Free-running 100 MHz clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Compares one observed value with its expected value and logs a miss
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Drives one cycle of requests; returns 1 time unit after the edge
   task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r);
      wrEn = w;
      din  = d;
      rdEn = r;
      @(posedge clock);
      #1;
   endtask

   // Main directed sequence
   initial begin
      testsRun    = 0;
      testsFailed = 0;
      reset = 1'b1;
      wrEn  = 1'b0;
      din   = 8'h00;
      rdEn  = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0);

      checkOutput("rst_empty",  32'(empty),       32'd1);
      checkOutput("rst_aempty", 32'(almostEmpty), 32'd1);
      checkOutput("rst_full",   32'(full),        32'd0);
      checkOutput("rst_afull",  32'(almostFull),  32'd0);
      checkOutput("rst_count",  32'(count),       32'd0);
      checkOutput("rst_dout",   32'(dout),        32'h00);
      checkOutput("rst_valid",  32'(doutValid),   32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      checkOutput("rst_ovf", 32'(overflow),  32'd0);
      checkOutput("rst_udf", 32'(underflow), 32'd0);
`endif

      // Fill with 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b0);
         checkOutput("fill_count",  32'(count),       32'(i + 1));
         checkOutput("fill_afull",  32'(almostFull),  32'((i + 1) >= 14));
         checkOutput("fill_full",   32'(full),        32'(i == 15));
         checkOutput("fill_aempty", 32'(almostEmpty), 32'((i + 1) <= 2));
         checkOutput("fill_valid",  32'(doutValid),   32'd0);
      end

      // Full with both requests: read 0x00 accepted, 0xAA dropped
      applyStimulus(1'b1, 8'hAA, 1'b1);
      checkOutput("fullrw_dout",  32'(dout),      32'h00);
      checkOutput("fullrw_valid", 32'(doutValid), 32'd1);
      checkOutput("fullrw_count", 32'(count),     32'd15);
      checkOutput("fullrw_full",  32'(full),      32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      checkOutput("fullrw_ovf", 32'(overflow), 32'd1);
`endif

      // Drain the remaining 0x01..0x0F; 0xAA must never appear
      for (int i = 1; i < 16; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
         checkOutput("drain_dout",   32'(dout),        32'(i));
         checkOutput("drain_valid",  32'(doutValid),   32'd1);
         checkOutput("drain_count",  32'(count),       32'(15 - i));
         checkOutput("drain_aempty", 32'(almostEmpty), 32'((15 - i) <= 2));
      end
      checkOutput("drain_empty", 32'(empty), 32'd1);

      // Empty with both requests: write 0x5C only, no write-through
      applyStimulus(1'b1, 8'h5C, 1'b1);
      checkOutput("emptyrw_count", 32'(count),     32'd1);
      checkOutput("emptyrw_valid", 32'(doutValid), 32'd0);
      checkOutput("emptyrw_dout",  32'(dout),      32'h0F);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      checkOutput("emptyrw_udf", 32'(underflow), 32'd1);
`endif
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("rd5c_dout",  32'(dout),      32'h5C);
      checkOutput("rd5c_valid", 32'(doutValid), 32'd1);
      checkOutput("rd5c_empty", 32'(empty),     32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("idle_valid", 32'(doutValid), 32'd0);
      checkOutput("idle_hold",  32'(dout),      32'h5C);

      // Preload 0x10..0x17, then 40 cycles of simultaneous read/write
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 8'(8'h10 + i), 1'b0);
      end
      checkOutput("pre_count", 32'(count), 32'd8);
      for (int k = 0; k < 40; k++) begin
         applyStimulus(1'b1, 8'(8'h20 + k), 1'b1);
         checkOutput("stream_count", 32'(count), 32'd8);
         checkOutput("stream_dout",  32'(dout),
                     (k < 8) ? 32'(8'h10 + k) : 32'(8'h20 + k - 8));
         checkOutput("stream_valid", 32'(doutValid), 32'd1);
      end

      // One more write for count=9, then reset mid-cycle
      applyStimulus(1'b1, 8'h99, 1'b0);
      checkOutput("pre_rst_count", 32'(count), 32'd9);
      wrEn = 1'b0;
      #3 reset = 1'b1;
      #1;
      checkOutput("arst_count",  32'(count),       32'd0);
      checkOutput("arst_empty",  32'(empty),       32'd1);
      checkOutput("arst_full",   32'(full),        32'd0);
      checkOutput("arst_afull",  32'(almostFull),  32'd0);
      checkOutput("arst_aempty", 32'(almostEmpty), 32'd1);
      checkOutput("arst_dout",   32'(dout),        32'h00);
      checkOutput("arst_valid",  32'(doutValid),   32'd0);
      #1 reset = 1'b0;
      @(posedge clock);
      #1;
      applyStimulus(1'b1, 8'h77, 1'b0);
      checkOutput("post_count", 32'(count), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("post_dout",  32'(dout),      32'h77);
      checkOutput("post_valid", 32'(doutValid), 32'd1);
      checkOutput("post_empty", 32'(empty),     32'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
